// File: rtl/sw_bank_pkg.sv
// Shared constants, types and helpers for the switch input bank.
// Level conventions: raw pins and LED drive are active-low, everything internal is active-high.
package sw_bank_pkg;

    // Raw pin level of a released switch; also the synchroniser reset value.
    localparam logic SW_RELEASED_N = 1'b1;
    localparam logic LED_OFF_N     = 1'b1;

    // Per-channel outputs, gathered so the top level can fan them out by field.
    typedef struct packed {
        logic state;
        logic press;
        logic rel;
        logic led_n;
    } sw_ch_out_t;

    // Width needed for a counter that reaches DEBOUNCE_CYCLES-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int debounce_cycles);
        return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, debounce counter, debounced level,
// press/release pulses and LED drive (toggle flop when SW_BANK_TOGGLE_EN is defined).
module sw_debounce_ch
    import sw_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_n,
    output sw_ch_out_t out
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          p;
    logic [CW-1:0] cnt;
    logic          state;
    logic          press;
    logic          rel;
    logic          accept;

    assign p      = ~sync[1];
    // New level has been held long enough: flip on this edge.
    assign accept = (p != state) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= {2{SW_RELEASED_N}};
            cnt   <= '0;
            state <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[0], sw_n};
            press <= accept & ~state;
            rel   <= accept &  state;
            // Any agreement with the current level, or an accepted change, restarts the count.
            if (p == state || accept)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (accept)
                state <= ~state;
        end
    end

`ifdef SW_BANK_TOGGLE_EN
    logic toggle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            toggle <= ~LED_OFF_N;
        else if (accept & ~state)
            toggle <= ~toggle;
    end

    assign out.led_n = ~toggle;
`else
    assign out.led_n = ~state;
`endif

    assign out.state = state;
    assign out.press = press;
    assign out.rel   = rel;

endmodule

// File: rtl/switch_input_bank.sv
// Multi-channel debounced front end for active-low push switches.
// Optional SW_BANK_TOGGLE_EN: each press flips the channel LED instead of following the level.
module switch_input_bank
    import sw_bank_pkg::*;
#(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_n,
    output logic [NUM_SW-1:0] sw_state,
    output logic [NUM_SW-1:0] sw_press,
    output logic [NUM_SW-1:0] sw_release,
    output logic [NUM_SW-1:0] led_n
);

    sw_ch_out_t ch_out [NUM_SW];

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .sw_n (sw_n[i]),
            .out  (ch_out[i])
        );

        assign sw_state[i]   = ch_out[i].state;
        assign sw_press[i]   = ch_out[i].press;
        assign sw_release[i] = ch_out[i].rel;
        assign led_n[i]      = ch_out[i].led_n;
    end

endmodule
